// File: rtl/activation_unit_if.sv
// Stream and LUT-programming signals of the activation stage.
// slave: the activation unit itself; master: the block feeding it and consuming its results.
interface activation_unit_if #(
    parameter int Q_SIZE = 16,
    parameter int MODE_W = 2,
    parameter int LUT_AW = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [Q_SIZE-1:0]     in_data;
    logic [MODE_W-1:0]     in_mode;

    logic                  out_valid;
    logic                  out_ready;
    logic [Q_SIZE-1:0]     out_data;

    logic                  lut_we;
    logic [LUT_AW-1:0]     lut_addr;
    logic [2*Q_SIZE-1:0]   lut_wdata;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready, lut_we, lut_addr, lut_wdata,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready, lut_we, lut_addr, lut_wdata,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/activation_unit.sv
// Piecewise-linear activation stage: y = sat(A*x + B) from a 64-entry
// coefficient LUT indexed by the top bits of x, or identity / ReLU.
// Four register stages (capture, multiply, add, saturate/select) give a
// 3-cycle accept-to-output latency; the whole pipe stalls as one unit.
module activation_unit #(
    parameter int Q_INT         = 4,
    parameter int Q_FRAC        = 12,
    parameter int ACT_LUT_DEPTH = 6,
    parameter int ACT_MASK_SIZE = 2
) (
    input logic              clk,
    input logic              rst,
    activation_unit_if.slave bus
);
    localparam int Q_SIZE      = Q_INT + Q_FRAC;
    localparam int P_SIZE      = 2 * Q_SIZE;
    localparam int LUT_ENTRIES = 1 << ACT_LUT_DEPTH;

    localparam logic [ACT_MASK_SIZE-1:0] MODE_RELU = ACT_MASK_SIZE'(1);
    localparam logic [ACT_MASK_SIZE-1:0] MODE_LUT  = ACT_MASK_SIZE'(2);

    // Coefficient storage, {A, B} per entry; deliberately not reset.
    logic [P_SIZE-1:0] lut_mem [LUT_ENTRIES];

    logic                     en;
    logic [ACT_LUT_DEPTH-1:0] lut_idx;

    // Stage 1: captured sample and its coefficients.
    logic                      s1_valid;
    logic signed [Q_SIZE-1:0]  s1_x;
    logic [ACT_MASK_SIZE-1:0]  s1_mode;
    logic [P_SIZE-1:0]         s1_coef;
    logic signed [Q_SIZE-1:0]  coef_a;
    logic signed [Q_SIZE-1:0]  coef_b;
    logic signed [P_SIZE-1:0]  prod;

    // Stage 2: Q8.24 product.
    logic                      s2_valid;
    logic signed [Q_SIZE-1:0]  s2_x;
    logic [ACT_MASK_SIZE-1:0]  s2_mode;
    logic signed [Q_SIZE-1:0]  s2_b;
    logic signed [P_SIZE-1:0]  s2_p;
    logic signed [P_SIZE-1:0]  sum;

    // Stage 3: unsaturated 32-bit sum.
    logic                      s3_valid;
    logic signed [Q_SIZE-1:0]  s3_x;
    logic [ACT_MASK_SIZE-1:0]  s3_mode;
    logic signed [P_SIZE-1:0]  s3_sum;
    logic [P_SIZE-Q_SIZE:0]    sum_upper;
    logic                      sum_ovf;
    logic [Q_SIZE-1:0]         result;

    // Output stage.
    logic                      out_valid_q;
    logic [Q_SIZE-1:0]         out_data_q;

    // Every stage moves together; a blocked output freezes the whole pipe.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Two's complement top bits: 0..31 cover [0,8), 32..63 cover [-8,0).
    assign lut_idx = bus.in_data[Q_SIZE-1 -: ACT_LUT_DEPTH];

    // Host writes land any cycle; the stage-1 read below sees the old word on a same-address collision.
    always_ff @(posedge clk) begin
        if (bus.lut_we) begin
            lut_mem[bus.lut_addr] <= bus.lut_wdata;
        end
    end

    // Capture the sample and its {A, B} on the accept edge so later LUT writes cannot touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_mode  <= '0;
            s1_coef  <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_x     <= bus.in_data;
            s1_mode  <= bus.in_mode;
            s1_coef  <= lut_mem[lut_idx];
        end
    end

    assign coef_a = s1_coef[P_SIZE-1:Q_SIZE];
    assign coef_b = s1_coef[Q_SIZE-1:0];
    // The multiplier only toggles for LUT-mode samples.
    assign prod   = (s1_mode == MODE_LUT) ? P_SIZE'(coef_a) * P_SIZE'(s1_x) : '0;

    // Register the product A*x.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_mode  <= '0;
            s2_b     <= '0;
            s2_p     <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_x     <= s1_x;
            s2_mode  <= s1_mode;
            s2_b     <= coef_b;
            s2_p     <= prod;
        end
    end

    // Arithmetic shift floors toward -inf; no rounding term is added.
    assign sum = (s2_p >>> Q_FRAC) + P_SIZE'(s2_b);

    // Register the full-width sum ahead of saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_x     <= '0;
            s3_mode  <= '0;
            s3_sum   <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_x     <= s2_x;
            s3_mode  <= s2_mode;
            s3_sum   <= sum;
        end
    end

    // The sum fits Q4.12 only when every bit above bit 14 matches the sign.
    assign sum_upper = s3_sum[P_SIZE-1:Q_SIZE-1];
    assign sum_ovf   = !((&sum_upper) || !(|sum_upper));

    // Select the per-mode result; modes 00 and 11 both pass x through.
    always_comb begin
        result = s3_x;
        case (s3_mode)
            MODE_RELU: result = s3_x[Q_SIZE-1] ? '0 : s3_x;
            MODE_LUT: begin
                if (sum_ovf) begin
                    result = s3_sum[P_SIZE-1] ? {1'b1, {(Q_SIZE-1){1'b0}}}
                                              : {1'b0, {(Q_SIZE-1){1'b1}}};
                end else begin
                    result = s3_sum[Q_SIZE-1:0];
                end
            end
            default: result = s3_x;
        endcase
    end

    // Output register; held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            out_valid_q <= s3_valid;
            out_data_q  <= result;
        end
    end
endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit: accepted samples push an expected
// result computed from a plain-arithmetic model; a monitor pops on each output.
module tb_activation_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    activation_unit_if #(.Q_SIZE(16), .MODE_W(2), .LUT_AW(6)) bus ();

    activation_unit #(
        .Q_INT(4), .Q_FRAC(12), .ACT_LUT_DEPTH(6), .ACT_MASK_SIZE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] d;
        int          acc_edge;
        bit          lat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] lut_m [64];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          dir_use = 0;
    logic [15:0] dir_exp = '0;
    bit          lat_chk = 0;

    // Reference: real-number semantics of the piecewise-linear rule.
    function automatic logic [15:0] ref_y(input logic [15:0] x, input logic [1:0] m,
                                          input logic [31:0] c);
        longint xs, a, b, p, q, s;
        logic [15:0] r;
        xs = longint'($signed(x));
        a  = longint'($signed(c[31:16]));
        b  = longint'($signed(c[15:0]));
        case (m)
            2'd1: r = (xs < 0) ? 16'h0000 : x;
            2'd2: begin
                p = a * xs;
                q = p / 4096;
                if (p < 0 && (p % 4096) != 0) q = q - 1;
                s = q + b;
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                r = s[15:0];
            end
            default: r = x;
        endcase
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor then scoreboard, both evaluated mid-cycle.
    initial begin : mon
        bit          stalled_prev;
        logic [15:0] held;
        exp_t        e;
        logic [5:0]  idx;
        stalled_prev = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled_prev = 0;
                sbq.delete();
            end else begin
                if (bus.out_valid) begin
                    if (stalled_prev) begin
                        checks++;
                        if (bus.out_data !== held) begin
                            errors++;
                            $display("FAIL stall_hold got %h expected %h", bus.out_data, held);
                        end
                    end
                    if (bus.out_ready) begin
                        if (sbq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out got %h expected no output", bus.out_data);
                        end else begin
                            e = sbq.pop_front();
                            checks++;
                            if (bus.out_data !== e.d) begin
                                errors++;
                                $display("FAIL out_data got %h expected %h", bus.out_data, e.d);
                            end
                            if (e.lat && !stalled_prev) begin
                                checks++;
                                if (cyc - e.acc_edge != 3) begin
                                    errors++;
                                    $display("FAIL latency got %0d expected 3", cyc - e.acc_edge);
                                end
                            end
                        end
                        stalled_prev = 0;
                    end else begin
                        checks++;
                        if (bus.in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL in_ready_stall got %b expected 0", bus.in_ready);
                        end
                        stalled_prev = 1;
                        held = bus.out_data;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    idx = bus.in_data[15:10];
                    e.d = dir_use ? dir_exp : ref_y(bus.in_data, bus.in_mode, lut_m[idx]);
                    e.acc_edge = cyc + 1;
                    e.lat = lat_chk;
                    sbq.push_back(e);
                end
                if (bus.lut_we) lut_m[bus.lut_addr] = bus.lut_wdata;
            end
        end
    end

    task automatic lut_write(input logic [5:0] a, input logic [31:0] w);
        bus.lut_we = 1'b1;
        bus.lut_addr = a;
        bus.lut_wdata = w;
        @(posedge clk); #1;
        bus.lut_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input logic [1:0] m, input bit use_c,
                        input logic [15:0] ec, input bit lat);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_data = x;
        bus.in_mode = m;
        dir_use = use_c;
        dir_exp = ec;
        lat_chk = lat;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready 0 expected 1 within 200 cycles");
        end
        bus.in_valid = 1'b0;
        dir_use = 0;
        lat_chk = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", sbq.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_mode = '0;
        bus.out_ready = 1'b1;
        bus.lut_we = 1'b0;
        bus.lut_addr = '0;
        bus.lut_wdata = '0;

        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data got %h expected 0000", bus.out_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b expected 1", bus.in_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 64; i++) lut_write(6'(i), $urandom);
        lut_write(6'd6, 32'h0800_0400);
        lut_write(6'd32, 32'h7FFF_8000);
        lut_write(6'd63, 32'h0001_0000);

        // identity and latency
        send(16'h1800, 2'b00, 1, 16'h1800, 1);
        drain();
        send(16'h1800, 2'b11, 1, 16'h1800, 1);
        drain();

        // ReLU
        send(16'hF000, 2'b01, 1, 16'h0000, 0);
        send(16'h0400, 2'b01, 1, 16'h0400, 0);
        send(16'h8000, 2'b01, 1, 16'h0000, 0);
        drain();

        // LUT segment
        send(16'h1A00, 2'b10, 1, 16'h1100, 0);
        drain();

        // saturation and floor
        lut_write(6'd6, 32'h7FFF_7FFF);
        send(16'h1A00, 2'b10, 1, 16'h7FFF, 0);
        send(16'h8000, 2'b10, 1, 16'h8000, 0);
        send(16'hFFFF, 2'b10, 1, 16'hFFFF, 0);
        drain();

        // read-before-write collision on address 6
        lut_write(6'd6, 32'h0800_0400);
        bus.lut_we = 1'b1;
        bus.lut_addr = 6'd6;
        bus.lut_wdata = 32'h1000_0000;
        send(16'h1A00, 2'b10, 1, 16'h1100, 0);
        bus.lut_we = 1'b0;
        send(16'h1A00, 2'b10, 1, 16'h1A00, 0);
        drain();

        // back-to-back with a 4-cycle consumer stall
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'($urandom), 2'b10, 0, 16'h0, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // reset with samples in flight; LUT entry 6 must survive
        lut_write(6'd6, 32'h0800_0400);
        send(16'h0100, 2'b00, 0, 16'h0, 0);
        send(16'h0200, 2'b01, 0, 16'h0, 0);
        send(16'h0300, 2'b10, 0, 16'h0, 0);
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %b expected 1", bus.out_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b expected 1", bus.in_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(16'h1A00, 2'b10, 1, 16'h1100, 0);
        drain();

        // randomized traffic with random stalls and LUT rewrites
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 16'($urandom);
            bus.in_mode   = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.lut_we    = ($urandom_range(0, 7) == 0);
            bus.lut_addr  = 6'($urandom);
            bus.lut_wdata = $urandom;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.lut_we = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/activation_unit.md
# activation_unit

Pipelined piecewise-linear activation stage that sits directly downstream of the neuron units (NU) and consumes their saturated Q4.12 accumulator results. Each sample is indexed into a 64-entry coefficient LUT and becomes y = sat(A·x + B), or passes through identity or ReLU as selected. Results go back to the XY memory write path. It uses a valid/ready stream on both sides, sustains one sample per cycle, and has a host-side LUT write port.

## Interface
Parameters:
- Q_INT, 4: integer bits of data and coefficients (sign included).
- Q_FRAC, 12: fractional bits; Q_SIZE = Q_INT + Q_FRAC = 16.
- ACT_LUT_DEPTH, 6: LUT address width (64 entries).
- ACT_MASK_SIZE, 2: mode select width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  stage can accept a sample.
- in_data  in  Q_SIZE  signed Q4.12 sample x.
- in_mode  in  ACT_MASK_SIZE  per-sample mode: 00 identity, 01 ReLU, 10 LUT, 11 identity.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  Q_SIZE  signed Q4.12 result y.
- lut_we  in  1  LUT write strobe.
- lut_addr  in  ACT_LUT_DEPTH  LUT write address.
- lut_wdata  in  2·Q_SIZE  {A[31:16], B[15:0]}, both signed Q4.12.

## Operation
- Pipeline enable: en = !out_valid || out_ready. in_ready = en, driven combinationally from out_ready and out_valid. A transfer occurs when in_valid && in_ready.
- S1 (capture): registers x and mode. LUT index = x[15:10], the top ACT_LUT_DEPTH bits in two's complement.
  - Addresses 0–31 cover x ∈ [0, 8). Addresses 32–63 cover x ∈ [−8, 0). Each segment is 0.25 wide.
  - The {A, B} read for the sample is captured on its accept cycle and held through stalls. Later LUT writes never affect a sample already accepted.
- S2 (multiply): p = A·x, a signed 32-bit Q8.24 value, computed in LUT mode only.
- S3 (add/saturate), by mode:
  - LUT mode: s = (p >>> Q_FRAC) + sign-extended B. The shift is arithmetic, so it floors toward −∞, with no rounding. s is 32-bit.
  - Saturation: s > 32767 gives 0x7FFF; s < −32768 gives 0x8000; otherwise s[15:0].
  - Identity (00, 11): y = x.
  - ReLU (01): y = x[15] ? 0 : x.
- All of S1–S3 advance only when en = 1. Valid bits shift with data. A stalled output holds out_data stable.
- LUT is a 64×32 synchronous RAM.
  - Writes are accepted any cycle, regardless of stream state.
  - Same-cycle write and accept to the same address: the accepted sample uses the old entry (read-before-write).
- LUT contents are not reset and are undefined until written. Bench and firmware must program every entry used.

## Timing
- Latency is 3 cycles. A sample accepted at edge n appears with out_valid = 1 after edge n+3, if no stall occurs.
- Throughput is 1 sample/cycle with out_ready held high.
- Stall behaviour:
  - out_valid && !out_ready freezes all stages and drops in_ready in the same cycle.
  - Bubbles between valid samples are not compressed.
  - Sample order is always preserved, with no loss or duplication.
- Reset: all stage valid bits = 0 and out_valid = 0 immediately on rst assertion. out_data = 0x0000. in_ready = 1 while reset is held and after it.
- Reset mid-stream discards all in-flight samples and leaves LUT contents intact.
- A LUT write becomes visible to samples accepted on the cycle after lut_we.

## Test plan
- Identity: mode 00, x = 0x1800 (1.5) → out_data 0x1800, out_valid exactly 3 cycles after accept; mode 11 with the same x gives the same result.
- ReLU: mode 01, x = 0xF000 (−1.0) → 0x0000. x = 0x0400 → 0x0400. x = 0x8000 → 0x0000.
- LUT: write addr 6 = {0x0800, 0x0400} (A = 0.5, B = 0.25). Mode 10, x = 0x1A00 (1.625, index 6) → 0x1100 (1.0625).
- Saturation:
  - Addr 6 = {0x7FFF, 0x7FFF}, x = 0x1A00 → 0x7FFF.
  - Addr 32 = {0x7FFF, 0x8000}, x = 0x8000 → 0x8000.
  - Floor check: addr 63 = {0x0001, 0x0000}, x = 0xFFFF → 0xFFFF.
- Backpressure and collision:
  - Stream 8 LUT-mode samples back-to-back and hold out_ready low for 4 cycles mid-stream → 8 results in order, none lost or repeated, in_ready low during the stall.
  - Write addr 6 on the same cycle a sample with index 6 is accepted → that sample uses the old coefficients, the next one uses the new.
- Reset mid-operation: assert rst with 3 samples in flight → out_valid = 0 immediately, no stale outputs after release. A previously programmed LUT entry still produces the correct result.
